// File: rtl/get_cert_request_sequencer_pkg.sv
// Shared constants and state encoding for the GET_CERTIFICATE request sequencer.
package get_cert_request_sequencer_pkg;

    localparam logic [7:0]  GC_VERSION    = 8'h01;
    localparam logic [7:0]  GC_OPCODE     = 8'h82;
    localparam int          HDR_FIELD_W   = 8;
    localparam int          HDR_W         = 4 * HDR_FIELD_W;
    localparam int          MSG_LEN_DEF   = 2088;
    localparam logic [15:0] MIN_CHAIN_LEN = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_UPDATE   = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

endpackage

// File: rtl/get_cert_request_sequencer_chunk_calc.sv
// Next-offset / next-length arithmetic for one completed certificate chunk.
module get_cert_chunk_calc #(
    parameter int CHUNK_LEN = 256
) (
    input  logic [15:0] offset,
    input  logic [15:0] rsp_bytes,
    input  logic [15:0] chain_len,
    output logic [15:0] new_off,
    output logic [15:0] next_len,
    output logic        overflow,
    output logic        complete
);

    logic [16:0] sum;
    logic [15:0] remain;

    // 17-bit sum so an offset wrap past 64K is seen as overflow, not a small offset
    assign sum      = {1'b0, offset} + {1'b0, rsp_bytes};
    assign new_off  = sum[15:0];
    assign overflow = sum > {1'b0, chain_len};
    assign complete = sum == {1'b0, chain_len};
    assign remain   = chain_len - sum[15:0];
    assign next_len = (remain > 16'(CHUNK_LEN)) ? 16'(CHUNK_LEN) : remain;

endmodule

// File: rtl/get_cert_request_sequencer.sv
// Issues the GET_CERTIFICATE request sequence that reads one slot's certificate chain.
// Optional per-chunk retry on responder ERROR is enabled by defining GET_CERT_RETRY_EN.
//
// state    | meaning
// IDLE     | waiting for start
// ISSUE    | request presented on header/payload, waiting for msg_ready
// WAIT_RSP | request accepted, waiting for the parsed response
// UPDATE   | advance offset / decide done, error or next chunk
// DONE     | one-cycle done pulse
// ERROR    | one-cycle error pulse
module get_cert_request_sequencer
    import get_cert_request_sequencer_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int CHUNK_LEN = 256,
    parameter int MSG_LEN   = MSG_LEN_DEF,
`ifdef GET_CERT_RETRY_EN
    parameter int MAX_RETRIES = 3,
`endif
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SLOT_W-1:0]     slot,
    input  logic                  abort,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic [HDR_W-1:0]      header,
    output logic [MSG_LEN-33:0]   payload,
    input  logic                  rsp_valid,
    input  logic                  rsp_error,
    input  logic [15:0]           rsp_bytes,
    input  logic [15:0]           rsp_chain_len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            chunks_issued,
    output logic [15:0]           cur_offset
);

    state_t            state, state_n;
    logic [SLOT_W-1:0] slot_q;
    logic [15:0]       req_len;
    logic [15:0]       chain_len;
    logic [15:0]       rsp_bytes_q;
    logic              first_chunk;
    logic              start_any, start_go, accept, rsp_take, advance;
    logic [15:0]       new_off, next_len;
    logic              overflow, complete;

`ifdef GET_CERT_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_go;
`endif

    get_cert_chunk_calc #(.CHUNK_LEN(CHUNK_LEN)) u_chunk_calc (
        .offset    (cur_offset),
        .rsp_bytes (rsp_bytes_q),
        .chain_len (chain_len),
        .new_off   (new_off),
        .next_len  (next_len),
        .overflow  (overflow),
        .complete  (complete)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_any = 1'b0;
        start_go  = 1'b0;
        accept    = 1'b0;
        rsp_take  = 1'b0;
        advance   = 1'b0;
`ifdef GET_CERT_RETRY_EN
        retry_go  = 1'b0;
`endif
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    start_any = 1'b1;
                    if (32'(slot) < NUM_SLOTS) begin
                        start_go = 1'b1;
                        state_n  = ST_ISSUE;
                    end else begin
                        state_n  = ST_ERROR;
                    end
                end
                ST_ISSUE: if (msg_ready) begin
                    accept  = 1'b1;
                    state_n = ST_WAIT_RSP;
                end
                ST_WAIT_RSP: if (rsp_valid) begin
                    if (rsp_error) begin
`ifdef GET_CERT_RETRY_EN
                        if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                            retry_go = 1'b1;
                            state_n  = ST_ISSUE;
                        end else begin
                            state_n  = ST_ERROR;
                        end
`else
                        state_n = ST_ERROR;
`endif
                    end else if (rsp_bytes == 16'd0 || rsp_bytes > req_len) begin
                        state_n = ST_ERROR;
                    end else if (first_chunk && rsp_chain_len < MIN_CHAIN_LEN) begin
                        state_n = ST_ERROR;
                    end else begin
                        rsp_take = 1'b1;
                        state_n  = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (overflow)      state_n = ST_ERROR;
                    else if (complete) state_n = ST_DONE;
                    else begin
                        advance = 1'b1;
                        state_n = ST_ISSUE;
                    end
                end
                ST_DONE:  state_n = ST_IDLE;
                ST_ERROR: state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q        <= '0;
            req_len       <= '0;
            chain_len     <= '0;
            rsp_bytes_q   <= '0;
            first_chunk   <= 1'b0;
            chunks_issued <= '0;
            cur_offset    <= '0;
        end else begin
            if (start_any) begin
                chunks_issued <= '0;
                cur_offset    <= '0;
                chain_len     <= '0;
            end
            if (start_go) begin
                slot_q      <= slot;
                req_len     <= 16'(CHUNK_LEN);
                first_chunk <= 1'b1;
            end
            if (accept && chunks_issued != 8'hFF) chunks_issued <= chunks_issued + 8'd1;
            if (rsp_take) begin
                rsp_bytes_q <= rsp_bytes;
                first_chunk <= 1'b0;
                if (first_chunk) chain_len <= rsp_chain_len;
            end
            if (advance) begin
                cur_offset <= new_off;
                req_len    <= next_len;
            end
        end
    end

`ifdef GET_CERT_RETRY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    retry_cnt <= '0;
        else if (start_any || rsp_take) retry_cnt <= '0;
        else if (retry_go)             retry_cnt <= retry_cnt + 1'b1;
    end
`endif

    assign msg_valid = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);
    assign header    = msg_valid ? {GC_VERSION, GC_OPCODE, 8'(slot_q), 8'h00} : '0;
    assign payload   = msg_valid ? {cur_offset, req_len, {(MSG_LEN - 64){1'b0}}} : '0;

endmodule

// File: tb/tb_get_cert_request_sequencer.sv
// Directed self-checking bench for get_cert_request_sequencer (6 slots so out-of-range slots exist).
module tb_get_cert_request_sequencer;

    localparam int NUM_SLOTS = 6;
    localparam int MSG_LEN   = 2088;
    localparam int PW        = MSG_LEN - 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    slot = '0;
    logic          abort = 1'b0;
    logic          msg_valid;
    logic          msg_ready = 1'b0;
    logic [31:0]   header;
    logic [PW-1:0] payload;
    logic          rsp_valid = 1'b0;
    logic          rsp_error = 1'b0;
    logic [15:0]   rsp_bytes = '0;
    logic [15:0]   rsp_chain_len = '0;
    logic          busy, done, error;
    logic [7:0]    chunks_issued;
    logic [15:0]   cur_offset;

    int total = 0;
    int bad = 0;

    get_cert_request_sequencer #(.NUM_SLOTS(NUM_SLOTS), .CHUNK_LEN(256), .MSG_LEN(MSG_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .slot(slot), .abort(abort),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .header(header), .payload(payload),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_bytes(rsp_bytes),
        .rsp_chain_len(rsp_chain_len), .busy(busy), .done(done), .error(error),
        .chunks_issued(chunks_issued), .cur_offset(cur_offset)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pl(input logic [15:0] o, input logic [15:0] l);
        logic [PW-1:0] p;
        p = '0;
        p[PW-1 -: 32] = {o, l};
        return p;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL reset_msg_valid got=%0h exp=0", msg_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if ({done, error} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%0b exp=00", {done, error}); end
        total++; if (chunks_issued !== 8'd0) begin bad++; $display("FAIL reset_chunks got=%0h exp=0", chunks_issued); end
        total++; if (cur_offset !== 16'd0) begin bad++; $display("FAIL reset_offset got=%0h exp=0", cur_offset); end
        total++; if (header !== 32'd0) begin bad++; $display("FAIL reset_header got=%0h exp=0", header); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_chain(input string name, input logic [2:0] s, input logic [31:0] exp_hdr,
                              input logic [15:0] chain, input int n,
                              input logic [15:0] offs [3], input logic [15:0] lens [3]);
        start = 1'b1; slot = s;
        step();
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL %s_valid%0d got=%0h exp=1", name, k, msg_valid); end
            total++; if (header !== exp_hdr) begin bad++; $display("FAIL %s_header%0d got=%h exp=%h", name, k, header, exp_hdr); end
            total++; if (payload !== pl(offs[k], lens[k])) begin bad++;
                $display("FAIL %s_req%0d got=%h exp=%h", name, k, payload[PW-1 -: 32], {offs[k], lens[k]}); end
            total++; if (cur_offset !== offs[k]) begin bad++; $display("FAIL %s_offset%0d got=%h exp=%h", name, k, cur_offset, offs[k]); end
            msg_ready = 1'b1;
            step();
            msg_ready = 1'b0;
            total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_drop%0d got=%0h exp=0", name, k, msg_valid); end
            total++; if (chunks_issued !== 8'(k + 1)) begin bad++; $display("FAIL %s_chunks%0d got=%0d exp=%0d", name, k, chunks_issued, k + 1); end
            rsp_valid = 1'b1; rsp_bytes = lens[k]; rsp_chain_len = chain;
            step();
            rsp_valid = 1'b0;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_early_done%0d got=%0h exp=0", name, k, done); end
            step();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done got=%0h exp=1", name, done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL %s_no_error got=%0h exp=0", name, error); end
        step();
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL %s_idle got=%0b exp=00", name, {done, busy}); end
        total++; if (chunks_issued !== 8'(n)) begin bad++; $display("FAIL %s_chunks_hold got=%0d exp=%0d", name, chunks_issued, n); end
        total++; if (cur_offset !== offs[n-1]) begin bad++; $display("FAIL %s_offset_hold got=%h exp=%h", name, cur_offset, offs[n-1]); end
    endtask

    task automatic test_backpressure();
        start = 1'b1; slot = 3'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%0h exp=1", i, msg_valid); end
            total++; if (header !== 32'h01820200) begin bad++; $display("FAIL bp_header%0d got=%h exp=01820200", i, header); end
            total++; if (payload !== pl(16'h0000, 16'h0100)) begin bad++; $display("FAIL bp_req%0d got=%h exp=00000100", i, payload[PW-1 -: 32]); end
            total++; if (chunks_issued !== 8'd0) begin bad++; $display("FAIL bp_chunks%0d got=%0d exp=0", i, chunks_issued); end
            step();
        end
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        total++; if (chunks_issued !== 8'd1) begin bad++; $display("FAIL bp_accept got=%0d exp=1", chunks_issued); end
        total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%0h exp=0", msg_valid); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_abort_idle got=%0h exp=0", busy); end
    endtask

    task automatic test_abort();
        start = 1'b1; slot = 3'd1;
        step();
        start = 1'b0;
        msg_ready = 1'b1; abort = 1'b1;
        step();
        msg_ready = 1'b0; abort = 1'b0;
        total++; if ({busy, msg_valid} !== 2'b00) begin bad++; $display("FAIL abort_issue got=%0b exp=00", {busy, msg_valid}); end
        total++; if (chunks_issued !== 8'd0) begin bad++; $display("FAIL abort_issue_chunks got=%0d exp=0", chunks_issued); end
        start = 1'b1; slot = 3'd3;
        step();
        start = 1'b0;
        msg_ready = 1'b1;
        step();
        msg_ready = 1'b0;
        abort = 1'b1; rsp_valid = 1'b1; rsp_bytes = 16'h0100; rsp_chain_len = 16'h0100;
        step();
        abort = 1'b0;
        total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL abort_wait got=%0b exp=000", {busy, done, error}); end
        step();
        rsp_valid = 1'b0;
        total++; if ({busy, msg_valid, done} !== 3'b000) begin bad++; $display("FAIL abort_late_rsp got=%0b exp=000", {busy, msg_valid, done}); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%0h exp=0", done); end
    endtask

    task automatic test_error_rsp();
        start = 1'b1; slot = 3'd0;
        step();
        start = 1'b0;
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        rsp_valid = 1'b1; rsp_bytes = 16'h0100; rsp_chain_len = 16'h0300;
        step();
        rsp_valid = 1'b0;
        step();
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
`ifdef GET_CERT_RETRY_EN
        for (int r = 0; r < 3; r++) begin
            rsp_valid = 1'b1; rsp_error = 1'b1;
            step();
            rsp_valid = 1'b0; rsp_error = 1'b0;
            total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL retry_valid%0d got=%0h exp=1", r, msg_valid); end
            total++; if (payload !== pl(16'h0100, 16'h0100)) begin bad++; $display("FAIL retry_req%0d got=%h exp=01000100", r, payload[PW-1 -: 32]); end
            msg_ready = 1'b1; step(); msg_ready = 1'b0;
            total++; if (chunks_issued !== 8'(3 + r)) begin bad++; $display("FAIL retry_chunks%0d got=%0d exp=%0d", r, chunks_issued, 3 + r); end
        end
`endif
        rsp_valid = 1'b1; rsp_error = 1'b1;
        step();
        rsp_valid = 1'b0; rsp_error = 1'b0;
        total++; if ({error, done} !== 2'b10) begin bad++; $display("FAIL rsp_err_pulse got=%0b exp=10", {error, done}); end
        step();
        total++; if ({error, busy} !== 2'b00) begin bad++; $display("FAIL rsp_err_idle got=%0b exp=00", {error, busy}); end
    endtask

    task automatic test_bad_input();
        logic [15:0] t_bytes [5] = '{16'h0200, 16'h0000, 16'h0002, 16'h0080, 16'h0004};
        logic [15:0] t_chain [5] = '{16'h0300, 16'h0300, 16'h0003, 16'h0050, 16'h0004};
        bit          t_upd   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit          t_err   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; slot = 3'd0;
            step();
            start = 1'b0;
            msg_ready = 1'b1; step(); msg_ready = 1'b0;
            rsp_valid = 1'b1; rsp_bytes = t_bytes[i]; rsp_chain_len = t_chain[i];
            step();
            rsp_valid = 1'b0;
            if (t_upd[i]) begin
                total++; if ({error, done, busy} !== 3'b001) begin bad++; $display("FAIL bad%0d_update got=%0b exp=001", i, {error, done, busy}); end
                step();
            end
            total++; if ({error, done} !== {t_err[i], ~t_err[i]}) begin bad++;
                $display("FAIL bad%0d_result got=%0b exp=%0b", i, {error, done}, {t_err[i], ~t_err[i]}); end
            step();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL bad%0d_idle got=%0h exp=0", i, busy); end
        end
        start = 1'b1; slot = 3'd6;
        step();
        start = 1'b0;
        total++; if ({error, msg_valid} !== 2'b10) begin bad++; $display("FAIL bad_slot_pulse got=%0b exp=10", {error, msg_valid}); end
        step();
        total++; if ({error, busy, msg_valid} !== 3'b000) begin bad++; $display("FAIL bad_slot_idle got=%0b exp=000", {error, busy, msg_valid}); end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; slot = 3'd4;
        step();
        start = 1'b0;
        msg_ready = 1'b1; step(); msg_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++; if ({busy, msg_valid, done} !== 3'b000) begin bad++; $display("FAIL midreset_idle got=%0b exp=000", {busy, msg_valid, done}); end
        total++; if (chunks_issued !== 8'd0) begin bad++; $display("FAIL midreset_chunks got=%0d exp=0", chunks_issued); end
        step();
        reset = 1'b1;
        step();
        start = 1'b1; slot = 3'd4;
        step();
        start = 1'b0;
        total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%0h exp=1", msg_valid); end
        total++; if (header !== 32'h01820400) begin bad++; $display("FAIL restart_header got=%h exp=01820400", header); end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    initial begin
        logic [15:0] offs_a [3] = '{16'h0000, 16'h0100, 16'h0200};
        logic [15:0] lens_a [3] = '{16'h0100, 16'h0100, 16'h0100};
        logic [15:0] lens_b [3] = '{16'h0100, 16'h0100, 16'h0050};
        test_reset();
        test_chain("full", 3'd5, 32'h01820500, 16'h0300, 3, offs_a, lens_a);
        test_chain("remainder", 3'd5, 32'h01820500, 16'h0250, 3, offs_a, lens_b);
        test_backpressure();
        test_abort();
        test_chain("after_abort", 3'd3, 32'h01820300, 16'h0300, 3, offs_a, lens_a);
        test_error_rsp();
        test_bad_input();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
